// File: rtl/sram_arbiter_if.sv
// Bus bundle between the two Avalon-MM-style requesters, the arbiter and the SRAM pins.
// The arbiter uses the slave modport; the requesters and SRAM device use master.
interface sram_arbiter_if;
    logic [18:0] p0_address;
    logic        p0_read;
    logic        p0_write;
    logic [15:0] p0_writedata;
    logic [1:0]  p0_byteenable;
    logic        p0_waitrequest;
    logic [15:0] p0_readdata;
    logic        p0_readdatavalid;

    logic [18:0] p1_address;
    logic        p1_read;
    logic        p1_write;
    logic [15:0] p1_writedata;
    logic [1:0]  p1_byteenable;
    logic        p1_waitrequest;
    logic [15:0] p1_readdata;
    logic        p1_readdatavalid;

    logic [18:0] sram_addr;
    logic [15:0] sram_dq_out;
    logic [15:0] sram_dq_in;
    logic        sram_dq_oe;
    logic        sram_ce_n;
    logic        sram_oe_n;
    logic        sram_we_n;
    logic [1:0]  sram_be_n;

    modport slave (
        input  p0_address, p0_read, p0_write, p0_writedata, p0_byteenable,
        output p0_waitrequest, p0_readdata, p0_readdatavalid,
        input  p1_address, p1_read, p1_write, p1_writedata, p1_byteenable,
        output p1_waitrequest, p1_readdata, p1_readdatavalid,
        output sram_addr, sram_dq_out, sram_dq_oe, sram_ce_n, sram_oe_n, sram_we_n, sram_be_n,
        input  sram_dq_in
    );

    modport master (
        output p0_address, p0_read, p0_write, p0_writedata, p0_byteenable,
        input  p0_waitrequest, p0_readdata, p0_readdatavalid,
        output p1_address, p1_read, p1_write, p1_writedata, p1_byteenable,
        input  p1_waitrequest, p1_readdata, p1_readdatavalid,
        input  sram_addr, sram_dq_out, sram_dq_oe, sram_ce_n, sram_oe_n, sram_we_n, sram_be_n,
        output sram_dq_in
    );
endinterface

// File: rtl/sram_arbiter.sv
// Two-port arbiter and access sequencer for a 16-bit asynchronous SRAM.
// Port 0 has priority; port 1 is granted after STARVE_LIMIT consecutive port-0 grants.
module sram_arbiter #(
    parameter int ACCESS_CYCLES = 2,
    parameter int STARVE_LIMIT  = 4
) (
    input  logic          clk,
    input  logic          reset,
    sram_arbiter_if.slave bus
);
    localparam logic [3:0] LAST_CYCLE = 4'(ACCESS_CYCLES);
    localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIMIT);

    typedef enum logic [1:0] {IDLE, ACCESS, WHOLD} state_t;

    state_t      state_reg, state_next;
    logic [3:0]  cycle_reg, cycle_next;
    logic        port_reg, port_next;
    logic        write_reg, write_next;
    logic [3:0]  starve_reg, starve_next;

    logic [18:0] addr_reg, addr_next;
    logic [15:0] dq_out_reg, dq_out_next;
    logic        dq_oe_reg, dq_oe_next;
    logic        ce_n_reg, ce_n_next;
    logic        oe_n_reg, oe_n_next;
    logic        we_n_reg, we_n_next;
    logic [1:0]  be_n_reg, be_n_next;

    logic [1:0]  req_read, req_write, req_any, waitrequest;
    logic [18:0] req_addr  [2];
    logic [15:0] req_wdata [2];
    logic [1:0]  req_be    [2];

    logic        grant_valid, grant_port, sel_write, read_done;

    assign req_read     = {bus.p1_read, bus.p0_read};
    assign req_write    = {bus.p1_write, bus.p0_write};
    assign req_addr[0]  = bus.p0_address;
    assign req_addr[1]  = bus.p1_address;
    assign req_wdata[0] = bus.p0_writedata;
    assign req_wdata[1] = bus.p1_writedata;
    assign req_be[0]    = bus.p0_byteenable;
    assign req_be[1]    = bus.p1_byteenable;

    // Grants only happen in IDLE; port 1 wins when port 0 is silent or it has starved long enough.
    assign grant_valid = (state_reg == IDLE) && !reset && (req_any != 2'b00);
    assign grant_port  = req_any[1] && (!req_any[0] || (starve_reg == STARVE_MAX));
    assign sel_write   = req_write[grant_port];
    assign read_done   = (state_reg == ACCESS) && (cycle_reg == LAST_CYCLE) && !write_reg;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_port
            logic [15:0] readdata_reg;
            logic        valid_reg;

            assign req_any[gi]     = req_read[gi] | req_write[gi];
            assign waitrequest[gi] = ~(grant_valid && (grant_port == 1'(gi)));

            always_ff @(posedge clk) begin
                if (reset) begin
                    readdata_reg <= '0;
                    valid_reg    <= 1'b0;
                end else begin
                    valid_reg <= read_done && (port_reg == 1'(gi));
                    if (read_done && (port_reg == 1'(gi))) begin
                        readdata_reg <= bus.sram_dq_in;
                    end
                end
            end
        end
    endgenerate

    assign bus.p0_waitrequest   = waitrequest[0];
    assign bus.p1_waitrequest   = waitrequest[1];
    assign bus.p0_readdata      = g_port[0].readdata_reg;
    assign bus.p1_readdata      = g_port[1].readdata_reg;
    assign bus.p0_readdatavalid = g_port[0].valid_reg;
    assign bus.p1_readdatavalid = g_port[1].valid_reg;

    assign bus.sram_addr   = addr_reg;
    assign bus.sram_dq_out = dq_out_reg;
    assign bus.sram_dq_oe  = dq_oe_reg;
    assign bus.sram_ce_n   = ce_n_reg;
    assign bus.sram_oe_n   = oe_n_reg;
    assign bus.sram_we_n   = we_n_reg;
    assign bus.sram_be_n   = be_n_reg;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg  <= IDLE;
            cycle_reg  <= '0;
            port_reg   <= 1'b0;
            write_reg  <= 1'b0;
            starve_reg <= '0;
            addr_reg   <= '0;
            dq_out_reg <= '0;
            dq_oe_reg  <= 1'b0;
            ce_n_reg   <= 1'b1;
            oe_n_reg   <= 1'b1;
            we_n_reg   <= 1'b1;
            be_n_reg   <= 2'b11;
        end else begin
            state_reg  <= state_next;
            cycle_reg  <= cycle_next;
            port_reg   <= port_next;
            write_reg  <= write_next;
            starve_reg <= starve_next;
            addr_reg   <= addr_next;
            dq_out_reg <= dq_out_next;
            dq_oe_reg  <= dq_oe_next;
            ce_n_reg   <= ce_n_next;
            oe_n_reg   <= oe_n_next;
            we_n_reg   <= we_n_next;
            be_n_reg   <= be_n_next;
        end
    end

    // Pin values are computed for the state being entered, so every SRAM pin comes from a flop.
    always_comb begin
        state_next  = state_reg;
        cycle_next  = cycle_reg;
        port_next   = port_reg;
        write_next  = write_reg;
        addr_next   = addr_reg;
        dq_out_next = dq_out_reg;
        dq_oe_next  = dq_oe_reg;
        ce_n_next   = ce_n_reg;
        oe_n_next   = oe_n_reg;
        we_n_next   = we_n_reg;
        be_n_next   = be_n_reg;

        starve_next = starve_reg;
        if (!req_any[1]) begin
            starve_next = '0;
        end else if (grant_valid) begin
            starve_next = grant_port ? 4'd0 : starve_reg + 4'd1;
        end

        case (state_reg)
            IDLE: begin
                if (grant_valid) begin
                    state_next = ACCESS;
                    cycle_next = 4'd1;
                    port_next  = grant_port;
                    write_next = sel_write;
                    addr_next  = req_addr[grant_port];
                    be_n_next  = ~req_be[grant_port];
                    ce_n_next  = 1'b0;
                    oe_n_next  = sel_write;
                    we_n_next  = ~sel_write;
                    dq_oe_next = sel_write;
                    if (sel_write) begin
                        dq_out_next = req_wdata[grant_port];
                    end
                end
            end
            ACCESS: begin
                if (cycle_reg == LAST_CYCLE) begin
                    if (write_reg) begin
                        // Release WE_n first; CE_n, data and address stay put for hold time.
                        state_next = WHOLD;
                        we_n_next  = 1'b1;
                    end else begin
                        state_next = IDLE;
                        ce_n_next  = 1'b1;
                        oe_n_next  = 1'b1;
                        be_n_next  = 2'b11;
                    end
                end else begin
                    cycle_next = cycle_reg + 4'd1;
                end
            end
            WHOLD: begin
                state_next = IDLE;
                ce_n_next  = 1'b1;
                oe_n_next  = 1'b1;
                we_n_next  = 1'b1;
                be_n_next  = 2'b11;
                dq_oe_next = 1'b0;
            end
            default: begin
                state_next = IDLE;
                ce_n_next  = 1'b1;
                oe_n_next  = 1'b1;
                we_n_next  = 1'b1;
                be_n_next  = 2'b11;
                dq_oe_next = 1'b0;
            end
        endcase
    end
endmodule

// File: tb/tb_sram_arbiter.sv
// Scoreboard bench for sram_arbiter: stimulus pushes expected reads, a monitor pops them
// on readdatavalid; pin timing, grant order, turnaround and reset are checked directly.
module tb_sram_arbiter;
    localparam int ACC = 2;

    logic clk;
    logic reset;
    int   cyc;
    int   pass_cnt;
    int   total_cnt;

    sram_arbiter_if bus();

    sram_arbiter #(.ACCESS_CYCLES(ACC), .STARVE_LIMIT(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // SRAM device model: unwritten words return a fixed pattern.
    logic [15:0] mem [0:1023];
    bit          written [0:1023];
    logic [9:0]  ma;
    logic [15:0] mword;

    function automatic logic [15:0] dflt(input logic [9:0] a);
        if (a == 10'h2B3) return 16'hBEEF;
        if (a == 10'h010) return 16'hABCD;
        return 16'h5000 + {6'd0, a};
    endfunction

    always_comb begin
        ma    = bus.sram_addr[9:0];
        mword = written[ma] ? mem[ma] : dflt(ma);
        bus.sram_dq_in = (!bus.sram_ce_n && !bus.sram_oe_n) ? mword : 16'hDEAD;
    end

    always @(posedge clk) begin
        if (!bus.sram_ce_n && !bus.sram_we_n) begin
            mem[ma] <= {bus.sram_be_n[1] ? mword[15:8] : bus.sram_dq_out[15:8],
                        bus.sram_be_n[0] ? mword[7:0]  : bus.sram_dq_out[7:0]};
            written[ma] <= 1'b1;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total_cnt++;
        if (act === req) pass_cnt++;
        else $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, req);
    endtask

    typedef struct {
        int          port;
        logic [15:0] data;
        int          due;
    } exp_t;

    exp_t sb[$];
    int   vcnt [2];
    int   glog[$];

    // Monitor: every valid pulse must match the oldest expected read.
    always @(negedge clk) begin
        for (int p = 0; p < 2; p++) begin
            logic        v;
            logic [15:0] d;
            exp_t        e;
            v = (p == 0) ? bus.p0_readdatavalid : bus.p1_readdatavalid;
            d = (p == 0) ? bus.p0_readdata : bus.p1_readdata;
            if (v) begin
                vcnt[p]++;
                check("sb_nonempty", 32'(sb.size() != 0), 32'h1);
                if (sb.size() != 0) begin
                    e = sb.pop_front();
                    $display("read done: port %0d data 0x%04h cycle %0d", p, d, cyc);
                    check("rd_port", p, e.port);
                    check("rd_data", 32'(d), 32'(e.data));
                    check("rd_latency", cyc, e.due);
                end
            end
        end
    end

    always @(negedge clk) begin
        if (!reset) begin
            if (!bus.p0_waitrequest) glog.push_back(0);
            if (!bus.p1_waitrequest) glog.push_back(1);
        end
    end

    task automatic drive(input int port, input logic rd, input logic wr, input logic [18:0] addr,
                         input logic [15:0] wd, input logic [1:0] be);
        if (port == 0) begin
            bus.p0_read = rd; bus.p0_write = wr; bus.p0_address = addr;
            bus.p0_writedata = wd; bus.p0_byteenable = be;
        end else begin
            bus.p1_read = rd; bus.p1_write = wr; bus.p1_address = addr;
            bus.p1_writedata = wd; bus.p1_byteenable = be;
        end
    endtask

    // Call just after a rising edge; returns just after the accepting edge.
    task automatic issue(input int port, input logic rd, input logic wr, input logic [18:0] addr,
                         input logic [15:0] wd, input logic [1:0] be,
                         input logic push, input logic [15:0] exp_data);
        bit ok;
        int acc;
        ok  = 0;
        acc = 0;
        drive(port, rd, wr, addr, wd, be);
        for (int n = 0; n < 60 && !ok; n++) begin
            @(negedge clk);
            if (((port == 0) ? bus.p0_waitrequest : bus.p1_waitrequest) == 1'b0) begin
                ok  = 1;
                acc = cyc;
            end
        end
        check($sformatf("accept_p%0d", port), 32'(ok), 32'h1);
        if (ok && push) sb.push_back('{port, exp_data, acc + ACC + 1});
        $display("issue: port %0d rd %0d wr %0d addr 0x%05h accepted %0d cycle %0d",
                 port, rd, wr, addr, ok, acc);
        @(posedge clk);
        #1;
        drive(port, 1'b0, 1'b0, 19'h0, 16'h0, 2'b00);
    endtask

    task automatic sync();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_pins(input string tag);
        check({tag, "_ce_n"},  32'(bus.sram_ce_n), 32'h1);
        check({tag, "_oe_n"},  32'(bus.sram_oe_n), 32'h1);
        check({tag, "_we_n"},  32'(bus.sram_we_n), 32'h1);
        check({tag, "_be_n"},  32'(bus.sram_be_n), 32'h3);
        check({tag, "_dq_oe"}, 32'(bus.sram_dq_oe), 32'h0);
        check({tag, "_addr"},  32'(bus.sram_addr), 32'h0);
        check({tag, "_dq_out"}, 32'(bus.sram_dq_out), 32'h0);
        check({tag, "_wait0"}, 32'(bus.p0_waitrequest), 32'h1);
        check({tag, "_wait1"}, 32'(bus.p1_waitrequest), 32'h1);
        check({tag, "_rdv0"},  32'(bus.p0_readdatavalid), 32'h0);
        check({tag, "_rdv1"},  32'(bus.p1_readdatavalid), 32'h0);
        check({tag, "_rdata0"}, 32'(bus.p0_readdata), 32'h0);
        check({tag, "_rdata1"}, 32'(bus.p1_readdata), 32'h0);
    endtask

    logic oe_tr [14];
    logic dq_tr [14];
    int   cnt;
    int   last_rd;
    int   first_wr;
    bit   gap;
    int   exp_order [10];

    initial begin
        pass_cnt  = 0;
        total_cnt = 0;
        vcnt[0]   = 0;
        vcnt[1]   = 0;
        exp_order = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1};
        reset     = 1'b1;

        // Reset with both ports requesting.
        drive(0, 1'b1, 1'b0, 19'h00111, 16'h0, 2'b11);
        drive(1, 1'b0, 1'b1, 19'h00222, 16'hFFFF, 2'b11);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check_reset_pins("reset");
        end
        @(posedge clk);
        #1;
        drive(0, 1'b0, 1'b0, 19'h0, 16'h0, 2'b00);
        drive(1, 1'b0, 1'b0, 19'h0, 16'h0, 2'b00);
        reset = 1'b0;
        sync();

        // Single p0 read.
        issue(0, 1'b1, 1'b0, 19'h1A2B3, 16'h0, 2'b11, 1'b1, 16'hBEEF);
        cnt = 0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (k == 0) begin
                check("rd_addr", 32'(bus.sram_addr), 32'h1A2B3);
                check("rd_be_n", 32'(bus.sram_be_n), 32'h0);
                check("rd_dq_oe", 32'(bus.sram_dq_oe), 32'h0);
            end
            if (!bus.sram_oe_n) cnt++;
        end
        check("rd_oe_cycles", cnt, ACC);
        sync();
        check("rd_p0_valids", vcnt[0], 1);
        check("rd_p1_valids", vcnt[1], 0);

        // p1 upper-byte write, then read back.
        issue(1, 1'b0, 1'b1, 19'h00010, 16'h1234, 2'b10, 1'b0, 16'h0);
        cnt = 0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            if (k == 0) begin
                check("wr_be_n", 32'(bus.sram_be_n), 32'h1);
                check("wr_dq_out", 32'(bus.sram_dq_out), 32'h1234);
                check("wr_dq_oe", 32'(bus.sram_dq_oe), 32'h1);
                check("wr_oe_n", 32'(bus.sram_oe_n), 32'h1);
            end
            if (k == 2) begin
                check("whold_we_n", 32'(bus.sram_we_n), 32'h1);
                check("whold_ce_n", 32'(bus.sram_ce_n), 32'h0);
                check("whold_dq_oe", 32'(bus.sram_dq_oe), 32'h1);
                check("whold_addr", 32'(bus.sram_addr), 32'h10);
            end
            if (!bus.sram_we_n) cnt++;
        end
        check("wr_we_cycles", cnt, ACC);
        sync();
        issue(1, 1'b1, 1'b0, 19'h00010, 16'h0, 2'b11, 1'b1, 16'h12CD);
        repeat (4) sync();

        // Read and write together count as a write with no valid pulse.
        issue(0, 1'b1, 1'b1, 19'h00030, 16'h7777, 2'b11, 1'b0, 16'h0);
        repeat (4) sync();
        issue(0, 1'b1, 1'b0, 19'h00030, 16'h0, 2'b11, 1'b1, 16'h7777);
        repeat (4) sync();

        // Starvation: both ports request continuously.
        glog.delete();
        fork
            begin
                for (int k = 0; k < 8; k++)
                    issue(0, 1'b1, 1'b0, 19'h00100 + 19'(k), 16'h0, 2'b11, 1'b1, 16'h5100 + 16'(k));
            end
            begin
                for (int k = 0; k < 2; k++)
                    issue(1, 1'b1, 1'b0, 19'h00200 + 19'(k), 16'h0, 2'b11, 1'b1, 16'h5200 + 16'(k));
            end
        join
        check("grant_count", glog.size(), 10);
        for (int k = 0; k < 10 && k < glog.size(); k++)
            check($sformatf("grant_%0d", k), glog[k], exp_order[k]);
        repeat (4) sync();

        // Turnaround: p0 read immediately followed by p1 write.
        fork
            issue(0, 1'b1, 1'b0, 19'h002B3, 16'h0, 2'b11, 1'b1, 16'hBEEF);
            issue(1, 1'b0, 1'b1, 19'h00020, 16'h5555, 2'b11, 1'b0, 16'h0);
            begin
                for (int k = 0; k < 14; k++) begin
                    @(negedge clk);
                    oe_tr[k] = bus.sram_oe_n;
                    dq_tr[k] = bus.sram_dq_oe;
                end
            end
        join
        last_rd  = -1;
        first_wr = -1;
        gap      = 0;
        for (int k = 0; k < 14; k++) if (!oe_tr[k]) last_rd = k;
        for (int k = last_rd + 1; k < 14; k++) if (dq_tr[k] && first_wr < 0) first_wr = k;
        for (int k = last_rd + 1; k < first_wr; k++) if (oe_tr[k] && !dq_tr[k]) gap = 1;
        check("ta_read_seen", 32'(last_rd >= 0), 32'h1);
        check("ta_write_after", 32'(first_wr > last_rd), 32'h1);
        check("ta_gap", 32'(gap), 32'h1);
        sync();

        // Reset during cycle 1 of a read.
        issue(0, 1'b1, 1'b0, 19'h00050, 16'h0, 2'b11, 1'b0, 16'h0);
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check_reset_pins("midrst");
        @(posedge clk);
        #1;
        reset = 1'b0;
        repeat (4) sync();
        issue(0, 1'b1, 1'b0, 19'h1A2B3, 16'h0, 2'b11, 1'b1, 16'hBEEF);
        repeat (8) sync();

        check("sb_drained", sb.size(), 0);
        check("p0_valid_total", vcnt[0], 12);
        check("p1_valid_total", vcnt[1], 3);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule

// File: doc/sram_arbiter.md
# sram_arbiter

Two-port arbiter and access sequencer for the board's external 16-bit asynchronous SRAM (19-bit word address), placed between the SRAM tristate pins and two Avalon-MM-style requesters. Port 0 is the real-time video frame reader; port 1 is the decoder's frame write/read path. The block grants one access at a time and generates the chip-enable, output-enable, write-enable and byte-enable timing. Port 0 has priority, and a starvation limit bounds how long port 1 can wait.

## Interface
- ACCESS_CYCLES, 2: cycles CE_n/OE_n or WE_n held active per access; legal range 1..15
- STARVE_LIMIT, 4: consecutive port-0 grants allowed while port 1 is requesting; legal range 1..15
- clk  in  1  system clock (50 MHz domain)
- reset  in  1  synchronous, active-high
- pN_address  in  19  word address (N = 0,1; the same port set exists for each)
- pN_read / pN_write  in  1  request strobes; held until accepted
- pN_writedata  in  16  write data
- pN_byteenable  in  2  active-high byte lanes
- pN_waitrequest  out  1  low only in the cycle the command is accepted
- pN_readdata  out  16  read data
- pN_readdatavalid  out  1  one-cycle pulse
- sram_addr  out  19  SRAM address
- sram_dq_out  out  16  SRAM write data
- sram_dq_in  in  16  SRAM read data
- sram_dq_oe  out  1  tristate enable for sram_dq_out
- sram_ce_n, sram_oe_n, sram_we_n  out  1  active-low SRAM controls
- sram_be_n  out  2  active-low byte enables

## Operation
- States:
  - IDLE
  - ACCESS: counts 1..ACCESS_CYCLES
  - WHOLD: one cycle after a write
- IDLE:
  - If no request: stay in IDLE.
  - Otherwise grant one port combinationally. pN_waitrequest is low for the granted port only; all other waitrequests stay high.
  - On the accepting edge, latch the address, data and byte enables, plus the direction and port ID, then go to ACCESS.
- Arbitration:
  - Port 0 wins by default.
  - starve_cnt (4-bit) increments on each port-0 grant made while p1 is requesting.
  - When starve_cnt equals STARVE_LIMIT and p1 is requesting, grant p1.
  - starve_cnt clears on any p1 grant, and in any cycle where p1 is not requesting.
- Read and write asserted together on one port: treated as a write; no readdatavalid is generated.
- ACCESS, read:
  - sram_ce_n=0, sram_oe_n=0, sram_dq_oe=0, sram_be_n = ~byteenable.
  - On the last ACCESS edge, capture sram_dq_in into pN_readdata, then return to IDLE.
  - pN_readdatavalid is high for exactly the following cycle (the IDLE cycle).
- ACCESS, write: sram_ce_n=0, sram_we_n=0, sram_oe_n=1, sram_dq_oe=1, sram_dq_out = latched data.
- WHOLD: sram_we_n=1; sram_ce_n=0, sram_dq_oe=1 and the address/data are held for data hold time; then go to IDLE.
- IDLE outputs:
  - sram_ce_n=1, sram_oe_n=1, sram_we_n=1, sram_be_n=2'b11, sram_dq_oe=0.
  - sram_addr keeps its last value.
  - This IDLE cycle is the guaranteed bus turnaround between a read and the next write.
- pN_readdata holds its last captured value until the next read for that port.
- Reset:
  - Every output takes its reset value on the next edge, from any state, and the state goes to IDLE.
  - An in-flight read produces no readdatavalid.
  - starve_cnt is cleared.

## Timing
- All SRAM pin outputs are registered. pN_waitrequest is combinational from the state and the request inputs.
- Reset values:
  - sram_ce_n=1, sram_oe_n=1, sram_we_n=1, sram_be_n=2'b11, sram_dq_oe=0.
  - sram_addr=0, sram_dq_out=0.
  - pN_waitrequest=1 while reset is high; pN_readdatavalid=0; pN_readdata=0.
- Read:
  - Accept edge E0; SRAM active in cycles 1..ACCESS_CYCLES.
  - Data captured at edge E(ACCESS_CYCLES); readdatavalid during cycle ACCESS_CYCLES+1.
  - Latency from accept to valid: ACCESS_CYCLES+1 cycles.
  - Back-to-back read throughput: one per ACCESS_CYCLES+1 cycles.
- Write:
  - WE_n low for cycles 1..ACCESS_CYCLES; WHOLD in cycle ACCESS_CYCLES+1.
  - Next accept possible in cycle ACCESS_CYCLES+2.
- A grant is never issued outside IDLE. Requests arriving during ACCESS or WHOLD wait, and are then arbitrated in the next IDLE cycle.

## Test plan
- Reset: hold reset for 3 cycles while both ports request. Required: all waitrequests stay 1, SRAM pins stay at their reset values, and no readdatavalid.
- Single read, ACCESS_CYCLES=2: p0 reads address 0x1A2B3, with the SRAM model returning 0xBEEF. Required:
  - sram_oe_n=0 for exactly 2 cycles.
  - p0_readdatavalid pulses 3 cycles after the accept, with p0_readdata=0xBEEF.
  - p1 sees no valid pulse.
- Write then read-back: p1 writes 0x00010 with data 0x1234 and byteenable 2'b10.
  - Required: sram_be_n=2'b01, sram_we_n low 2 cycles, then WHOLD with dq_oe=1.
  - Required: a following read returns 0x12xx, i.e. only the upper byte was written.
- Starvation: both ports request continuously with STARVE_LIMIT=4. Required grant order: p0,p0,p0,p0,p1,p0,p0,p0,p0,p1,...
- Turnaround: a p0 read is immediately followed by a p1 write. Required: at least one cycle with sram_oe_n=1 and sram_dq_oe=0 between the read's last ACCESS cycle and the first cycle with dq_oe=1.
- Mid-access reset: assert reset in cycle 1 of a read. Required: next edge returns all pins to reset values, no readdatavalid, and a new request after reset completes normally.
